// File: rtl/uart_arbiter.sv
// Two-requester arbiter sharing one UART: pushes a requester's packet into the
// transmit FIFO, collects its response from the receive FIFO, then signals done.
//
// state | meaning
// IDLE  | waiting for a request; grants and latches the winner's packet
// SEND  | pushing latched bytes into the UART transmit FIFO
// RECV  | popping response bytes, watching the idle-cycle timeout
// DONE  | one-cycle done/err pulse to the granted requester
module uart_arbiter #(
  parameter int TIMEOUT = 1000000
) (
  input  logic        CLK,
  input  logic        RST,
  input  logic        req0,
  input  logic        req1,
  input  logic [63:0] tx_pkt0,
  input  logic [63:0] tx_pkt1,
  input  logic [3:0]  tx_len0,
  input  logic [3:0]  tx_len1,
  input  logic [3:0]  rx_len0,
  input  logic [3:0]  rx_len1,
  output logic        done0,
  output logic        done1,
  output logic        err0,
  output logic        err1,
  output logic [63:0] rx_pkt0,
  output logic [63:0] rx_pkt1,
  output logic        send_flag,
  output logic [7:0]  send_data,
  input  logic        sendable,
  output logic        recv_flag,
  input  logic [7:0]  recv_data,
  input  logic        receivable
);

  localparam int CW = (TIMEOUT > 1) ? $clog2(TIMEOUT + 1) : 1;
  localparam logic [CW-1:0] TMR_LOAD = CW'(TIMEOUT - 1);

  typedef enum logic [1:0] {IDLE, SEND, RECV, DONE} state_t;

  state_t        state;
  logic          gnt;
  logic          ptr;
  logic [63:0]   pkt;
  logic [3:0]    tx_len_q;
  logic [3:0]    rx_len_q;
  logic [3:0]    idx;
  logic [CW-1:0] tmr;

  logic          gnt_nxt;
  logic          send_last;
  logic          fin_ok;
  logic          fin_to;

  function automatic logic [3:0] clamp8(input logic [3:0] len);
    return (len > 4'd8) ? 4'd8 : len;
  endfunction

  assign gnt_nxt   = (req0 & req1) ? ptr : req1;
  assign send_data = pkt[{idx[2:0], 3'b000} +: 8];
  assign send_flag = (state == SEND) && sendable && (idx < tx_len_q);
  assign recv_flag = (state == RECV) && receivable && (idx < rx_len_q);
  assign send_last = (tx_len_q == 4'd0) || (send_flag && (idx == tx_len_q - 4'd1));
  assign fin_ok    = (rx_len_q == 4'd0) || (recv_flag && (idx == rx_len_q - 4'd1));
  // Down-counter reloaded on entry and on every pop; zero means TIMEOUT idle cycles.
  assign fin_to    = (rx_len_q != 4'd0) && !recv_flag && (tmr == '0);

  always_ff @(posedge CLK) begin
    if (RST) begin
      state    <= IDLE;
      gnt      <= 1'b0;
      ptr      <= 1'b0;
      pkt      <= '0;
      tx_len_q <= '0;
      rx_len_q <= '0;
      idx      <= '0;
      tmr      <= '0;
      done0    <= 1'b0;
      done1    <= 1'b0;
      err0     <= 1'b0;
      err1     <= 1'b0;
      rx_pkt0  <= '0;
      rx_pkt1  <= '0;
    end else begin
      done0 <= 1'b0;
      done1 <= 1'b0;
      err0  <= 1'b0;
      err1  <= 1'b0;
      case (state)
        IDLE: begin
          if (req0 | req1) begin
            gnt      <= gnt_nxt;
            ptr      <= ~gnt_nxt;
            pkt      <= gnt_nxt ? tx_pkt1 : tx_pkt0;
            tx_len_q <= clamp8(gnt_nxt ? tx_len1 : tx_len0);
            rx_len_q <= clamp8(gnt_nxt ? rx_len1 : rx_len0);
            idx      <= '0;
            if (gnt_nxt) rx_pkt1 <= '0;
            else         rx_pkt0 <= '0;
            state    <= SEND;
          end
        end
        SEND: begin
          if (send_last) begin
            idx   <= '0;
            tmr   <= TMR_LOAD;
            state <= RECV;
          end else if (send_flag) begin
            idx <= idx + 4'd1;
          end
        end
        RECV: begin
          if (recv_flag) begin
            if (gnt) rx_pkt1[{idx[2:0], 3'b000} +: 8] <= recv_data;
            else     rx_pkt0[{idx[2:0], 3'b000} +: 8] <= recv_data;
            idx <= idx + 4'd1;
            tmr <= TMR_LOAD;
          end else if (!fin_to) begin
            tmr <= tmr - 1'b1;
          end
          if (fin_ok || fin_to) begin
            done0 <= ~gnt;
            done1 <= gnt;
            err0  <= ~gnt & fin_to;
            err1  <= gnt & fin_to;
            state <= DONE;
          end
        end
        DONE: state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_uart_arbiter.sv
// Scoreboard bench for uart_arbiter: models both UART FIFOs and the grant order,
// compares pushed bytes and completion records as the DUT produces them.
module tb_uart_arbiter;

  localparam int TO = 16;

  logic        CLK = 1'b0;
  logic        RST;
  logic        req0, req1;
  logic [63:0] tx_pkt0, tx_pkt1;
  logic [3:0]  tx_len0, tx_len1, rx_len0, rx_len1;
  logic        done0, done1, err0, err1;
  logic [63:0] rx_pkt0, rx_pkt1;
  logic        send_flag, sendable, recv_flag, receivable;
  logic [7:0]  send_data, recv_data;

  uart_arbiter #(.TIMEOUT(TO)) dut (
    .CLK(CLK), .RST(RST), .req0(req0), .req1(req1),
    .tx_pkt0(tx_pkt0), .tx_pkt1(tx_pkt1),
    .tx_len0(tx_len0), .tx_len1(tx_len1),
    .rx_len0(rx_len0), .rx_len1(rx_len1),
    .done0(done0), .done1(done1), .err0(err0), .err1(err1),
    .rx_pkt0(rx_pkt0), .rx_pkt1(rx_pkt1),
    .send_flag(send_flag), .send_data(send_data), .sendable(sendable),
    .recv_flag(recv_flag), .recv_data(recv_data), .receivable(receivable)
  );

  always #5 CLK = ~CLK;

  typedef struct {
    int          id;
    logic        err;
    logic [63:0] pkt;
  } done_t;

  done_t       exp_done[$];
  logic [7:0]  exp_tx[$];
  logic [7:0]  rx_q[$];
  logic [63:0] shadow[2];
  int          done_cnt[2];
  int          n_checks = 0;
  int          n_fail = 0;
  int          cyc = 0;
  int          push_cnt = 0;
  int          last_push_cyc = 0;
  int          done_cyc = 0;
  int          req_cyc = 0;
  int          snd_mode = 0;
  logic        m_ptr = 1'b0;
  logic        done0_d = 1'b0;
  logic        done1_d = 1'b0;

  task automatic check_eq(input string tag, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", tag, act, exp);
    end
  endtask

  always @(posedge CLK) cyc++;

  // UART FIFO side: inputs change 1 time unit after each rising edge
  initial forever begin
    @(posedge CLK);
    #1;
    sendable   = (snd_mode == 0) ? 1'b1 : ((cyc % 2) == 0);
    receivable = (rx_q.size() > 0);
    recv_data  = (rx_q.size() > 0) ? rx_q[0] : 8'h00;
  end

  always @(negedge CLK) begin
    if (!RST) begin
      check_eq("flags_excl", {63'd0, send_flag & recv_flag}, 64'd0);
      if (send_flag) begin
        check_eq("send_gate", {63'd0, sendable}, 64'd1);
        if (exp_tx.size() == 0) check_eq("send_unexpected", 64'd1, 64'd0);
        else check_eq("send_data", {56'd0, send_data}, {56'd0, exp_tx.pop_front()});
        push_cnt++;
        last_push_cyc = cyc;
      end
      if (recv_flag) begin
        check_eq("recv_gate", {63'd0, receivable}, 64'd1);
        if (rx_q.size() > 0) void'(rx_q.pop_front());
      end
      if (done0_d) check_eq("done0_pulse", {63'd0, done0}, 64'd0);
      if (done1_d) check_eq("done1_pulse", {63'd0, done1}, 64'd0);
      if (done0 | done1) begin
        check_eq("done_both", {63'd0, done0 & done1}, 64'd0);
        if (exp_done.size() == 0) begin
          check_eq("done_unexpected", 64'd1, 64'd0);
        end else begin
          done_t e;
          e = exp_done.pop_front();
          check_eq("done_id", done1 ? 64'd1 : 64'd0, 64'(e.id));
          check_eq("err", {63'd0, done1 ? err1 : err0}, {63'd0, e.err});
          check_eq("rx_pkt", done1 ? rx_pkt1 : rx_pkt0, e.pkt);
          check_eq("rx_pkt_other", done1 ? rx_pkt0 : rx_pkt1, shadow[e.id == 0 ? 1 : 0]);
          shadow[e.id] = e.pkt;
          done_cnt[e.id]++;
          done_cyc = cyc;
          if (e.id == 0) req0 = 1'b0;
          else           req1 = 1'b0;
        end
      end
      done0_d = done0;
      done1_d = done1;
    end
  end

  task automatic start_req(input int id, input logic [63:0] pkt, input int txl, input int rxl,
                           input int n_rx, input logic [7:0] mask, input logic err_exp);
    done_t e;
    int tc, rc;
    tc = (txl > 8) ? 8 : txl;
    rc = (rxl > 8) ? 8 : rxl;
    for (int k = 0; k < tc; k++) exp_tx.push_back(pkt[8*k +: 8]);
    e.id  = id;
    e.err = err_exp;
    e.pkt = '0;
    for (int k = 0; k < n_rx && k < rc; k++) begin
      rx_q.push_back(pkt[8*k +: 8] ^ mask);
      e.pkt[8*k +: 8] = pkt[8*k +: 8] ^ mask;
    end
    exp_done.push_back(e);
    if (id == 0) begin
      tx_pkt0 = pkt; tx_len0 = 4'(txl); rx_len0 = 4'(rxl); req0 = 1'b1;
    end else begin
      tx_pkt1 = pkt; tx_len1 = 4'(txl); rx_len1 = 4'(rxl); req1 = 1'b1;
    end
    req_cyc = cyc;
  endtask

  task automatic wait_done(input int id, input int target);
    int n;
    n = 0;
    while (done_cnt[id] < target && n < 200) begin
      @(posedge CLK);
      n++;
    end
    if (done_cnt[id] < target) check_eq("done_wait", 64'(done_cnt[id]), 64'(target));
  endtask

  task automatic contend(input logic [63:0] pa, input logic [63:0] pb);
    int first, second;
    first  = m_ptr ? 1 : 0;
    second = 1 - first;
    start_req(first, pa, 2, 1, 1, 8'h5A, 1'b0);
    start_req(second, pb, 1, 2, 2, 8'hC3, 1'b0);
    wait_done(first, done_cnt[first] + 1);
    wait_done(second, done_cnt[second] + 1);
    m_ptr = (first == 1);
  endtask

  initial begin
    RST = 1'b1;
    req0 = 1'b0; req1 = 1'b0;
    tx_pkt0 = '0; tx_pkt1 = '0;
    tx_len0 = '0; tx_len1 = '0; rx_len0 = '0; rx_len1 = '0;
    sendable = 1'b1; receivable = 1'b0; recv_data = '0;
    shadow[0] = '0; shadow[1] = '0;
    done_cnt[0] = 0; done_cnt[1] = 0;
    repeat (3) @(posedge CLK);
    @(negedge CLK);
    check_eq("reset_outputs", {58'd0, done0, done1, err0, err1, send_flag, recv_flag}, 64'd0);
    check_eq("reset_rx_pkt0", rx_pkt0, 64'd0);
    check_eq("reset_rx_pkt1", rx_pkt1, 64'd0);
    @(posedge CLK); #1;
    RST = 1'b0;

    // contention directly after reset, twice: 0,1,0,1
    @(posedge CLK); #1;
    contend(64'h1122334455667788, 64'h99AABBCCDDEEFF00);
    @(posedge CLK); #1;
    contend(64'h0F1E2D3C4B5A6978, 64'h8796A5B4C3D2E1F0);

    // loopback and minimum turnaround
    @(posedge CLK); #1;
    start_req(0, 64'h0807060504030201, 3, 3, 3, 8'h00, 1'b0);
    m_ptr = 1'b1;
    wait_done(0, done_cnt[0] + 1);
    check_eq("turnaround", 64'(done_cyc - req_cyc), 64'd7);
    check_eq("loopback_pkt", shadow[0], 64'h0000000000030201);

    // backpressure on the transmit side
    @(posedge CLK); #1;
    snd_mode = 1;
    push_cnt = 0;
    start_req(1, 64'hDEADBEEFCAFEF00D, 4, 2, 2, 8'h11, 1'b0);
    m_ptr = 1'b0;
    wait_done(1, done_cnt[1] + 1);
    check_eq("bp_push_cnt", 64'(push_cnt), 64'd4);
    snd_mode = 0;

    // length clamp with empty response
    @(posedge CLK); #1;
    push_cnt = 0;
    start_req(0, 64'hA1A2A3A4A5A6A7A8, 15, 0, 0, 8'h00, 1'b0);
    m_ptr = 1'b1;
    wait_done(0, done_cnt[0] + 1);
    check_eq("clamp_push_cnt", 64'(push_cnt), 64'd8);
    check_eq("clamp_done_gap", 64'(done_cyc - last_push_cyc), 64'd2);

    // receive clamp: rx_len 12 pops exactly 8
    @(posedge CLK); #1;
    start_req(1, 64'h0123456789ABCDEF, 2, 12, 8, 8'h3C, 1'b0);
    m_ptr = 1'b0;
    wait_done(1, done_cnt[1] + 1);

    // timeout: one byte of two arrives
    @(posedge CLK); #1;
    start_req(0, 64'h00000000000077EE, 1, 2, 1, 8'h0F, 1'b1);
    m_ptr = 1'b1;
    wait_done(0, done_cnt[0] + 1);

    // reset while waiting in RECV
    @(posedge CLK); #1;
    exp_tx.push_back(8'h44);
    exp_tx.push_back(8'h55);
    tx_pkt0 = 64'h0000000000005544; tx_len0 = 4'd2; rx_len0 = 4'd3; req0 = 1'b1;
    repeat (6) @(posedge CLK);
    #1;
    RST = 1'b1;
    req0 = 1'b0;
    @(posedge CLK); #1;
    check_eq("rst_outputs", {58'd0, done0, done1, err0, err1, send_flag, recv_flag}, 64'd0);
    check_eq("rst_rx_pkt0", rx_pkt0, 64'd0);
    check_eq("rst_rx_pkt1", rx_pkt1, 64'd0);
    check_eq("rst_pushes_kept", 64'(exp_tx.size()), 64'd0);
    shadow[0] = '0; shadow[1] = '0;
    m_ptr = 1'b0;
    RST = 1'b0;
    repeat (3) @(posedge CLK);
    #1;
    start_req(0, 64'h00000000BBAA9988, 4, 4, 4, 8'h66, 1'b0);
    wait_done(0, done_cnt[0] + 1);

    repeat (4) @(posedge CLK);
    check_eq("tx_left", 64'(exp_tx.size()), 64'd0);
    check_eq("done_left", 64'(exp_done.size()), 64'd0);
    check_eq("rx_left", 64'(rx_q.size()), 64'd0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout: got running expected finished");
    $fatal(1, "simulation time limit");
  end

endmodule

// File: doc/uart_arbiter.md
UART_ARBITER -- requirements
Module: uart_arbiter

Interface
REQ-001 SHALL have parameter TIMEOUT, default 1000000, giving the RECV-state idle cycles before abort.
REQ-002 SHALL have port CLK  input  1  sole clock, all state updates on rising edge.
REQ-003 SHALL have port RST  input  1  reset, synchronous, active-high.
REQ-004 SHALL have ports req0/req1  input  1  requester packet request, held high until own done.
REQ-005 SHALL have ports tx_pkt0/tx_pkt1  input  64  outbound bytes, byte k at [8k+7:8k].
REQ-006 SHALL have ports tx_len0/tx_len1  input  4  outbound byte count.
REQ-007 SHALL have ports rx_len0/rx_len1  input  4  expected response byte count.
REQ-008 SHALL have ports done0/done1  output  1  one-cycle completion pulse.
REQ-009 SHALL have ports err0/err1  output  1  timeout flag, valid with done.
REQ-010 SHALL have ports rx_pkt0/rx_pkt1  output  64  response bytes, byte k at [8k+7:8k].
REQ-011 SHALL have ports send_flag  output  1;  send_data  output  8;  sendable  input  1  UART transmit FIFO push interface.
REQ-012 SHALL have ports recv_flag  output  1;  recv_data  input  8;  receivable  input  1  UART receive FIFO pop interface; recv_data valid while receivable high, popped at edge with recv_flag.

Function
REQ-013 SHALL implement states IDLE, SEND, RECV, DONE.
REQ-014 IDLE: if any req high, SHALL grant one, latch its tx_pkt, tx_len, rx_len, clear the byte index, and go to SEND the next cycle.
REQ-015 Both req high in IDLE: SHALL grant the requester not granted last; the priority pointer updates at grant only.
REQ-016 tx_len or rx_len above 8 SHALL be clamped to 8 at latch time.
REQ-017 SEND: SHALL assert send_flag only in cycles where sendable is high, with send_data = latched byte[index], index+1 per push, LSB byte first.
REQ-018 SEND with latched tx_len 0 SHALL push nothing and go to RECV after one cycle; otherwise go to RECV the cycle after the last push.
REQ-019 RECV: SHALL assert recv_flag only when receivable is high, write recv_data into the granted rx_pkt byte[index], and increment the index from 0.
REQ-020 RECV SHALL go to DONE the cycle after the rx_len-th pop; with rx_len 0 it SHALL go to DONE immediately, without popping.
REQ-021 rx_pkt bytes at or above rx_len SHALL be zeroed at grant; the non-granted rx_pkt SHALL stay unchanged throughout.
REQ-022 RECV SHALL keep a cycle counter that clears on each pop and on entry. At TIMEOUT-1 without a pop it SHALL go to DONE with err set.
REQ-023 DONE: SHALL pulse done of the granted requester for exactly one cycle, with err for that requester valid in the same cycle, then return to IDLE.
REQ-024 A requester SHALL NOT be re-granted the same cycle its done pulses; req may drop in the DONE cycle.
REQ-025 send_flag and recv_flag SHALL never both be high, and neither SHALL be high outside SEND/RECV respectively.
REQ-026 Minimum turnaround, with sendable/receivable always high, SHALL be 1 + tx_len + rx_len + 1 cycles from grant to done.

Reset
REQ-027 RST high at an edge SHALL force IDLE, priority pointer to requester 0, all outputs 0, rx_pkt0/rx_pkt1 = 0, counters 0.
REQ-028 Reset mid-packet SHALL abort without a done pulse and SHALL NOT flush bytes already pushed into the UART FIFOs.

Verification
REQ-029 Loopback: req0, tx_pkt0=0x0807060504030201, tx_len0=3, rx_len0=3 -> send_data 01,02,03, then rx_pkt0=0x030201 and done0 at cycle 8, err0=0.
REQ-030 Contention: req0 and req1 rise together after reset -> requester 0 is served first, requester 1 next. Repeated contention alternates 0,1,0,1.
REQ-031 Backpressure: sendable toggles every other cycle, tx_len=4 -> exactly 4 pushes, each only in sendable cycles, byte order preserved.
REQ-032 Timeout: TIMEOUT=16, rx_len=2, one byte supplied then none -> done pulse with err=1, rx_pkt byte0 valid, byte1=0.
REQ-033 Clamp/zero: tx_len=15, rx_len=0 -> 8 pushes, done 2 cycles after last push, rx_pkt=0.
REQ-034 Reset during RECV -> next cycle IDLE, no done, all outputs 0; a new req0 is granted normally.
